trng_byte_packer: RTL and testbench
===================================

Name: trng_byte_packer

Overview:
- Downstream stage of the de-biaser; consumes its serial unbiased bit stream plus per-bit valid strobe, on the divided sampling clock.
- Packs accepted bits MSB-first into WIDTH-bit words.
- Runs a continuous repetition-count health test on the raw accepted bits and buffers completed words in a small FIFO.
- Presents words to the consumer (host readout / uo_out mux) over a valid/ready handshake.

Parameters:
- WIDTH, 8, output word width in bits (≥2).
- FIFO_DEPTH, 4, words buffered (power of two, ≥2).
- REP_LIMIT, 32, consecutive identical accepted bits that trip the health test (≥2).

Ports:
- i_clk  in  1  sampling clock, same domain as de-biaser.
- i_rst_n  in  1  reset. Asynchronous, active-low.
- i_enable  in  1  collection enable; low = input bits ignored, partial word held.
- i_bit  in  1  unbiased random bit.
- i_bit_valid  in  1  i_bit is valid this cycle.
- o_data  out  WIDTH  FIFO head word.
- o_valid  out  1  o_data valid (FIFO non-empty).
- i_ready  in  1  consumer accepts o_data this cycle.
- o_level  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- o_health_fail  out  1  sticky repetition-test failure.
- o_overflow  out  1  sticky: completed word dropped because FIFO full.
- i_clear_fail  in  1  synchronous clear of o_health_fail, o_overflow and health counter.

Behaviour:
- Reset (async assert, sync use): shift reg 0, bit counter 0, rep counter 0, last-bit 0, FIFO empty, o_data 0, o_valid 0, o_level 0, o_health_fail 0, o_overflow 0, FSM = ST_COLLECT.
- Accept = i_enable & i_bit_valid & (state == ST_COLLECT).
- On accept: shreg <= {shreg[WIDTH-2:0], i_bit}, bit counter +1.
- On the WIDTH-th accept, the word {shreg[WIDTH-2:0], i_bit} is pushed and the bit counter wraps to 0.
- Push latency: word is visible at o_data / o_valid the cycle after its last bit is accepted, if the FIFO was empty.
- Rep test on each accept:
  - i_bit == last-bit: rep counter +1, saturating at REP_LIMIT.
  - Otherwise: rep counter = 1.
  - last-bit <= i_bit.
- Rep counter reaching REP_LIMIT:
  - o_health_fail = 1 next cycle; FSM -> ST_FAIL.
  - Word completing on that same bit is NOT pushed.
  - Shift reg and bit counter cleared.
- ST_FAIL: no bits accepted; FIFO still drains normally. i_clear_fail -> ST_COLLECT, rep counter 0, o_health_fail 0.
- i_clear_fail in ST_COLLECT: clears o_overflow and rep counter. If the limit is reached that same cycle, clear wins: no failure, count restarts at 0.
- FIFO:
  - Pop when o_valid & i_ready.
  - Push with FIFO full and no pop: word dropped, o_overflow = 1 sticky, FIFO unchanged.
  - Push with FIFO full and simultaneous pop: both occur, level unchanged, no overflow.
  - Pop with FIFO empty: impossible (o_valid = 0).
- Read/write pointers wrap modulo FIFO_DEPTH. Level = push − pop count, range 0..FIFO_DEPTH.
- o_data is registered FIFO head; it holds its value while !i_ready.
- i_enable low mid-word: bit counter and shreg frozen; collection resumes on the next accept.
- Reset mid-word or mid-FIFO: all state discarded immediately, no partial word emitted.

Decomposition:
- Package trng_pkg:
  - Default constants TRNG_WORD_W = 8, TRNG_FIFO_DEPTH = 4, TRNG_REP_LIMIT = 32.
  - FSM state enum {ST_COLLECT, ST_FAIL}.
- One sub-module: trng_sync_fifo, a parameterised WIDTH × FIFO_DEPTH synchronous FIFO with push/pop/full/empty/level, async active-low reset.
- Packer, health test and FSM stay in the top module.

Test Plan:
- Basic packing: i_enable = 1, i_ready = 0, bits 1,0,1,1,0,0,1,0 on consecutive valid cycles -> o_valid = 1 one cycle after 8th bit, o_data = 0xB2, o_level = 1.
- Hold/pop: i_valid gaps and i_enable low for 5 cycles mid-word, then bits of 0x5A; i_ready = 1 -> o_data = 0x5A, o_valid drops the cycle after pop, o_level 1 -> 0.
- Overflow: i_ready = 0, 40 bits forming 0xA5 ×5 -> o_level = 4, o_overflow = 1, FIFO head still 0xA5. Pulse i_clear_fail -> o_overflow = 0. Full + pop + push in same cycle -> level stays 4, no overflow.
- Health trip: 31 ones then a 0 -> no failure. Then 32 ones -> o_health_fail = 1 the cycle after the 32nd; further bits not accepted; o_level unchanged. i_clear_fail -> collection resumes with bit counter 0.
- Clear priority: 32nd identical bit coincides with i_clear_fail -> o_health_fail stays 0.
- Reset mid-operation: assert i_rst_n low with 3 words queued and 5 bits partial -> o_valid = 0, o_level = 0, flags 0 immediately. After release, the next 8 bits form the first word.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared constants and FSM state type for the TRNG byte packer and its FIFO.
package trng_pkg;

    localparam int TRNG_WORD_W     = 8;
    localparam int TRNG_FIFO_DEPTH = 4;
    localparam int TRNG_REP_LIMIT  = 32;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FAIL    = 1'b1
    } trng_state_e;

endpackage

// File: rtl/trng_sync_fifo.sv
// Small synchronous FIFO with a registered head word, so the head is valid
// the cycle after a push into an empty FIFO.
module trng_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rd_next = rd_ptr + 1'b1;
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head follows the word that will sit at rd_ptr after this edge.
            if (do_pop) begin
                if (count >= LVL_W'(2)) begin
                    head <= mem[rd_next];
                end else if (do_push) begin
                    head <= push_data;
                end
            end else if (do_push && empty) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/trng_byte_packer.sv
// Packs accepted random bits MSB-first into words, runs a repetition-count
// health test on them and hands finished words out through a small FIFO.
module trng_byte_packer
    import trng_pkg::*;
#(
    parameter int WIDTH      = TRNG_WORD_W,
    parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH,
    parameter int REP_LIMIT  = TRNG_REP_LIMIT,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_bit,
    input  logic             i_bit_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [LVL_W-1:0] o_level,
    output logic             o_health_fail,
    output logic             o_overflow,
    input  logic             i_clear_fail
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

    function automatic logic [REP_W-1:0] rep_step(input logic [REP_W-1:0] cnt,
                                                  input logic             same);
        if (!same) begin
            return REP_W'(1);
        end else if (cnt >= REP_MAX) begin
            return REP_MAX;
        end else begin
            return cnt + 1'b1;
        end
    endfunction

    trng_state_e      state;
    trng_state_e      state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic             last_bit;
    logic             accept;
    logic             rep_trip;
    logic             word_done;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] word;
    logic             fifo_full;
    logic             fifo_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_COLLECT: if (rep_trip)     state_next = ST_FAIL;
            ST_FAIL:    if (i_clear_fail) state_next = ST_COLLECT;
            default:    state_next = ST_COLLECT;
        endcase
    end

    always_comb begin
        accept        = i_enable & i_bit_valid & (state == ST_COLLECT);
        o_health_fail = (state == ST_FAIL);
    end

    // A clear in the same cycle as the limit being reached cancels the trip.
    always_comb begin
        rep_next  = rep_step(rep_cnt, i_bit == last_bit);
        rep_trip  = accept & (rep_next == REP_MAX) & ~i_clear_fail;
        word      = {shreg[WIDTH-2:0], i_bit};
        word_done = accept & (bit_cnt == LAST_IDX);
        push      = word_done & ~rep_trip;
        pop       = i_ready & ~fifo_empty;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
            last_bit <= 1'b0;
        end else begin
            if (rep_trip) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (accept) begin
                shreg   <= word;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (i_clear_fail) begin
                rep_cnt <= '0;
            end else if (accept) begin
                rep_cnt <= rep_next;
            end
            if (accept) begin
                last_bit <= i_bit;
            end
        end
    end

    // A drop in the same cycle as a clear is still reported.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (push & fifo_full & ~pop) begin
            o_overflow <= 1'b1;
        end else if (i_clear_fail) begin
            o_overflow <= 1'b0;
        end
    end

    trng_sync_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .head      (o_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_level)
    );

    assign o_valid = ~fifo_empty;

endmodule

// File: tb/tb_trng_byte_packer.sv
// Bench for trng_byte_packer: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the packer.
module tb_trng_byte_packer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 32;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             bit_in;
    logic             bit_vld;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic [2:0]       level;
    logic             hfail;
    logic             ovf;
    logic             clr;

    int total = 0;
    int bad   = 0;

    int unsigned q[$];
    int          m_part;
    int          m_nbits;
    int          m_run;
    bit          m_last;
    bit          m_fail;
    bit          m_ovf;
    int          m_data;

    trng_byte_packer #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (DEPTH),
        .REP_LIMIT  (LIMIT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_bit         (bit_in),
        .i_bit_valid   (bit_vld),
        .o_data        (data),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_level       (level),
        .o_health_fail (hfail),
        .o_overflow    (ovf),
        .i_clear_fail  (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_part  = 0;
        m_nbits = 0;
        m_run   = 0;
        m_last  = 0;
        m_fail  = 0;
        m_ovf   = 0;
        m_data  = 0;
    endtask

    // One clock: drive inputs, advance the model by the same cycle, compare.
    task automatic step(input bit e, input bit v, input bit b, input bit r, input bit c);
        bit pop;
        bit acc;
        bit word_rdy;
        int w;
        int run_new;
        en = e; bit_vld = v; bit_in = b; ready = r; clr = c;
        @(posedge clk);
        pop      = (q.size() > 0) && r;
        acc      = e && v && !m_fail;
        word_rdy = 0;
        w        = 0;
        if (c) begin
            m_fail = 0;
            m_ovf  = 0;
        end
        if (acc) begin
            run_new = (b == m_last) ? ((m_run + 1 > LIMIT) ? LIMIT : m_run + 1) : 1;
            m_last  = b;
            m_part  = ((m_part << 1) | int'(b)) & 'hFF;
            m_nbits++;
            if (run_new == LIMIT && !c) begin
                m_fail  = 1;
                m_part  = 0;
                m_nbits = 0;
            end else if (m_nbits == WIDTH) begin
                word_rdy = 1;
                w        = m_part;
                m_nbits  = 0;
            end
            m_run = c ? 0 : run_new;
        end else if (c) begin
            m_run = 0;
        end
        if (word_rdy && q.size() == DEPTH && !pop) begin
            m_ovf = 1;
        end else begin
            if (pop) void'(q.pop_front());
            if (word_rdy) q.push_back(w);
        end
        if (q.size() > 0) m_data = int'(q[0]);
        #1;
        check("valid", valid, q.size() > 0);
        check("level", level, q.size());
        check("health_fail", hfail, m_fail);
        check("overflow", ovf, m_ovf);
        check("data", data, m_data);
    endtask

    task automatic send_word(input logic [7:0] w, input bit r);
        for (int i = 7; i >= 0; i--) step(1, 1, w[i], r, 0);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, 0, 0, r, 0);
    endtask

    initial begin
        logic [7:0] pat;
        rst_n = 0; en = 0; bit_in = 0; bit_vld = 0; ready = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_data", data, 0);
        check("rst_fail", hfail, 0);
        check("rst_ovf", ovf, 0);
        #2 rst_n = 1;

        // Basic packing of 0xB2.
        pat = 8'hB2;
        for (int i = 7; i >= 1; i--) step(1, 1, pat[i], 0, 0);
        check("b2_not_yet", valid, 0);
        step(1, 1, pat[0], 0, 0);
        check("b2_valid", valid, 1);
        check("b2_data", data, 32'hB2);
        check("b2_level", level, 1);
        step(0, 0, 0, 1, 0);
        check("b2_popped", valid, 0);

        // Gaps and enable low mid-word, then pop of 0x5A.
        pat = 8'h5A;
        for (int i = 7; i >= 4; i--) begin
            step(1, 1, pat[i], 0, 0);
            step(1, 0, 1, 0, 0);
        end
        for (int i = 0; i < 5; i++) step(0, 1, ~pat[3], 0, 0);
        for (int i = 3; i >= 0; i--) step(1, 1, pat[i], 0, 0);
        check("5a_data", data, 32'h5A);
        check("5a_level", level, 1);
        step(0, 0, 0, 1, 0);
        check("5a_level_after", level, 0);
        check("5a_valid_after", valid, 0);

        // Overflow, sticky flag clear, full + pop + push.
        for (int k = 0; k < 5; k++) send_word(8'hA5, 0);
        check("ovf_level", level, 4);
        check("ovf_flag", ovf, 1);
        check("ovf_head", data, 32'hA5);
        step(0, 0, 0, 0, 1);
        check("ovf_cleared", ovf, 0);
        pat = 8'hA5;
        for (int i = 7; i >= 1; i--) step(1, 1, pat[i], 0, 0);
        step(1, 1, pat[0], 1, 0);
        check("fullpop_level", level, 4);
        check("fullpop_ovf", ovf, 0);
        idle(5, 1);

        // Health trip: 31 ones pass, 32 ones fail.
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 31; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        check("h31_ok", hfail, 0);
        for (int i = 0; i < 31; i++) step(1, 1, 1, 0, 0);
        check("h31b_ok", hfail, 0);
        step(1, 1, 1, 0, 0);
        check("h32_fail", hfail, 1);
        check("h32_level", level, 4);
        for (int i = 0; i < 5; i++) step(1, 1, i[0], 0, 0);
        check("hfail_sticky", hfail, 1);
        check("hfail_level", level, 4);
        step(0, 0, 0, 0, 1);
        check("hclear", hfail, 0);
        idle(6, 1);
        send_word(8'h3C, 0);
        check("resume_data", data, 32'h3C);
        check("resume_level", level, 1);
        idle(2, 1);

        // Clear coinciding with the 32nd identical bit.
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 31; i++) step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1);
        check("clr_priority", hfail, 0);
        step(1, 1, 0, 1, 0);
        idle(6, 1);

        // Random traffic, then a stretch biased towards long runs of ones.
        for (int n = 0; n < 2000; n++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 1) != 0, $urandom_range(0, 63) == 0);
        for (int n = 0; n < 600; n++)
            step(1, $urandom_range(0, 9) < 8, $urandom_range(0, 31) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);

        // Reset with words queued and a partial word in flight.
        step(0, 0, 0, 1, 1);
        idle(6, 1);
        for (int k = 0; k < 3; k++) send_word(8'h69, 0);
        for (int i = 0; i < 5; i++) step(1, 1, i[0], 0, 0);
        check("pre_rst_level", level, 3);
        #2 rst_n = 0;
        #1;
        model_reset();
        check("mid_rst_valid", valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_fail", hfail, 0);
        check("mid_rst_ovf", ovf, 0);
        #2 rst_n = 1;
        send_word(8'hC3, 0);
        check("post_rst_data", data, 32'hC3);
        check("post_rst_level", level, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
